// File: rtl/rr_mux_arb_if.sv
// Handshake bundle for rr_mux_arb: N producer channels in, one registered consumer channel out.
interface rr_mux_arb_if #(
  parameter int N = 4,
  parameter int W = 2
) ();
  localparam int CW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  out_chan;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/rr_mux_arb.sv
// N-channel registered round-robin multiplexer with valid/ready on every port.
// Optional macro RR_MUX_STICKY_EN lets a channel keep the grant for up to BURST_MAX beats.
module rr_mux_arb #(
  parameter int N         = 4,
  parameter int W         = 2,
  parameter int BURST_MAX = 4
) (
  input logic         clk,
  input logic         rst_n,
  rr_mux_arb_if.slave bus
);
  localparam int CW = $clog2(N);

  if (N < 2 || BURST_MAX < 1) begin : g_bad_cfg
    $error("rr_mux_arb: N must be >= 2 and BURST_MAX >= 1");
  end

  logic [CW-1:0] ptr_p0;
  logic [CW-1:0] chan_p0;
  logic [W-1:0]  data_p0;
  logic          vld_p0;

  logic          load;
  logic          xfer;
  logic          rr_vld;
  logic [CW-1:0] rr_idx;
  logic          grant_vld;
  logic [CW-1:0] grant_idx;
  logic [W-1:0]  grant_data;

  // Held low while in reset so nothing is accepted before the register is live.
  assign load = rst_n && (!vld_p0 || bus.out_ready);
  assign xfer = load && grant_vld;

  // Walk from the highest offset down so the nearest valid channel after ptr wins.
  always_comb begin
    int            idx;
    logic [CW-1:0] sel;
    idx    = 0;
    sel    = '0;
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_p0) + k;
      if (idx >= N) idx = idx - N;
      sel = CW'(idx);
      if (bus.in_valid[sel]) begin
        rr_vld = 1'b1;
        rr_idx = sel;
      end
    end
  end

`ifdef RR_MUX_STICKY_EN
  localparam int BW = $clog2(BURST_MAX + 1);

  logic [CW-1:0] last_p0;
  logic [BW-1:0] cnt_p0;
  logic          stick;

  assign stick     = bus.in_valid[last_p0] && (cnt_p0 < BW'(BURST_MAX));
  assign grant_vld = stick || rr_vld;
  assign grant_idx = stick ? last_p0 : rr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_p0 <= '0;
      cnt_p0  <= '0;
    end else if (xfer) begin
      last_p0 <= grant_idx;
      cnt_p0  <= stick ? cnt_p0 + BW'(1) : BW'(1);
    end
  end
`else
  assign grant_vld = rr_vld;
  assign grant_idx = rr_idx;
`endif

  assign grant_data = bus.in_data[int'(grant_idx)*W +: W];

  always_comb begin
    bus.in_ready = '0;
    if (xfer) bus.in_ready[grant_idx] = 1'b1;
  end

  // Stage p0: single output register, refilled in the same cycle it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      chan_p0 <= '0;
      ptr_p0  <= '0;
    end else if (load) begin
      if (grant_vld) begin
        vld_p0  <= 1'b1;
        data_p0 <= grant_data;
        chan_p0 <= grant_idx;
        ptr_p0  <= (grant_idx == CW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        vld_p0  <= 1'b0;
      end
    end
  end

  assign bus.out_valid = vld_p0;
  assign bus.out_data  = data_p0;
  assign bus.out_chan  = chan_p0;
endmodule

// File: tb/tb_rr_mux_arb.sv
// Scoreboard bench for rr_mux_arb: directed scenarios plus randomized traffic against a queue-based model.
module tb_rr_mux_arb;
  localparam int N  = 4;
  localparam int W  = 2;
  localparam int BM = 4;
`ifdef RR_MUX_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    int           chan;
    logic [W-1:0] data;
  } beat_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  beat_t q[$];
  int    m_ptr;
  bit    m_ov;
  int    m_last;
  int    m_cnt;

  rr_mux_arb_if #(.N(N), .W(W)) bus ();

  rr_mux_arb #(.N(N), .W(W), .BURST_MAX(BM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit stuck(input logic [N-1:0] v);
    return STICKY && v[m_last] && (m_cnt < BM);
  endfunction

  // Reference arbiter: sticky channel first, else first valid channel scanning upward from ptr.
  function automatic int model_grant(input logic [N-1:0] v);
    if (stuck(v)) return m_last;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_cycle();
    bit   load_m;
    int   g;
    int   exp_rdy;
    bit   st;
    chk("out_valid", bus.out_valid, m_ov);
    load_m  = rst_n && (!m_ov || bus.out_ready);
    g       = load_m ? model_grant(bus.in_valid) : -1;
    exp_rdy = (g >= 0) ? (1 << g) : 0;
    chk("in_ready", bus.in_ready, exp_rdy);
    if (load_m) begin
      if (g >= 0) begin
        st = stuck(bus.in_valid);
        q.push_back('{g, bus.in_data[g*W +: W]});
        m_cnt  = st ? m_cnt + 1 : 1;
        m_last = g;
        m_ptr  = (g + 1) % N;
        m_ov   = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr  = 0;
    m_ov   = 1'b0;
    m_last = 0;
    m_cnt  = 0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_beat: got beat chan %0d data %0h, expected no beat", bus.out_chan, bus.out_data);
      end else begin
        b = q.pop_front();
        chk("sb_out_chan", bus.out_chan, b.chan);
        chk("sb_out_data", bus.out_data, b.data);
      end
    end
  end

  initial begin
    int exp_seq[10];
    logic [W-1:0] d;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    model_reset();
    set_in('1, '1, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_chan", bus.out_chan, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    step();
    rst_n = 1'b1;

    // Fairness: all four channels valid, data equals channel index.
    set_in(4'b1111, {2'b11, 2'b10, 2'b01, 2'b00}, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fair_chan", bus.out_chan, k % 4);
      chk("fair_data", bus.out_data, k % 4);
    end

    // Backpressure on a ch2 beat.
    set_in(4'b0100, {2'b00, 2'b01, 2'b00, 2'b00}, 1'b1);
    step();
    chk("bp_first_chan", bus.out_chan, 2);
    set_in(4'b0100, {2'b00, 2'b10, 2'b00, 2'b00}, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_chan", bus.out_chan, 2);
      chk("bp_hold_data", bus.out_data, 2'b01);
      chk("bp_hold_rdy", bus.in_ready, 0);
    end
    for (int k = 0; k < 3; k++) begin
      d = W'(k + 2);
      set_in(4'b0100, {2'b00, d, 2'b00, 2'b00}, 1'b1);
      step();
      chk("bp_rel_chan", bus.out_chan, 2);
      chk("bp_rel_data", bus.out_data, d);
    end

    // Wrap/skip from ptr=3.
    set_in(4'b0101, {2'b00, 2'b10, 2'b00, 2'b11}, 1'b1);
    step();
    chk("wrap_chan0", bus.out_chan, 0);
    step();
    chk("wrap_chan2", bus.out_chan, 2);
    step();
    chk("wrap_chan0b", bus.out_chan, 0);

    // Idle keeps ptr (now 1).
    set_in(4'b0000, '0, 1'b1);
    step();
    chk("idle_valid", bus.out_valid, 0);
    step();
    chk("idle_valid2", bus.out_valid, 0);
    set_in(4'b1111, {2'b11, 2'b10, 2'b01, 2'b00}, 1'b1);
    step();
    chk("idle_ptr_kept", bus.out_chan, 1);

    // Burst behaviour with ch1 and ch3 continuously valid.
    reset_pulse();
    if (STICKY) exp_seq = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1};
    else        exp_seq = '{1, 3, 1, 3, 1, 3, 1, 3, 1, 3};
    set_in(4'b1010, {2'b11, 2'b10, 2'b01, 2'b00}, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("burst_chan", bus.out_chan, exp_seq[k]);
    end

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      set_in(N'($urandom), (N*W)'($urandom), ($urandom_range(0, 3) != 0));
      step();
    end

    // Reset while a beat is held.
    set_in(4'b1111, '1, 1'b1);
    step();
    set_in(4'b1111, '1, 1'b0);
    step();
    chk("pre_rst_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    bus.out_ready = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_chan", bus.out_chan, 0);
    chk("mid_rst_rdy", bus.in_ready, 0);
    @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;
    set_in(4'b1010, {2'b11, 2'b10, 2'b01, 2'b00}, 1'b1);
    step();
    chk("post_rst_chan", bus.out_chan, 1);
    chk("post_rst_data", bus.out_data, 2'b01);

    set_in(4'b0000, '0, 1'b1);
    for (int k = 0; k < 3; k++) step();
    chk("sb_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
